// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared SM3 constants, word type, expander state and rotate helper
package sm3_pkg;

  localparam int SM3_ROUNDS      = 64;
  localparam int SM3_BLOCK_WORDS = 16;

  // Bit 0 is the most significant bit of a message word.
  typedef logic [0:31] sm3_word_t;

  typedef enum logic {
    IDLE,
    RUN
  } exp_state_e;

  // 32-bit rotate-left by a constant amount in 0..31.
  function automatic sm3_word_t rotl32(input sm3_word_t x, input int unsigned n);
    rotl32 = (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sm3_p1.sv
// rtl/sm3_p1.sv - combinational SM3 P1 permutation
module sm3_p1
  import sm3_pkg::*;
(
  input  sm3_word_t x_i,
  output sm3_word_t y_o
);

  assign y_o = x_i ^ rotl32(x_i, 15) ^ rotl32(x_i, 23);

endmodule

// File: rtl/sm3_msg_expander.sv
// rtl/sm3_msg_expander.sv - SM3 message expander producing one (W_j, W'_j) pair per round
module sm3_msg_expander
  import sm3_pkg::*;
(
  input  logic         input_clk,
  input  logic         input_rst,
  input  logic         input_block_valid,
  input  logic [0:511] input_block,
  output logic         output_block_ready,
  output logic         output_w_valid,
  input  logic         input_w_ready,
  output logic [0:31]  output_w,
  output logic [0:31]  output_wp,
  output logic [5:0]   output_j,
  output logic         output_done
);

  exp_state_e state_q, state_d;
  logic [5:0] j_q, j_d;
  logic       done_q, done_d;
  sm3_word_t  r_q [SM3_BLOCK_WORDS];
  sm3_word_t  r_d [SM3_BLOCK_WORDS];
  sm3_word_t  p1_in;
  sm3_word_t  p1_out;
  sm3_word_t  n_word;

  sm3_p1 u_p1 (
    .x_i (p1_in),
    .y_o (p1_out)
  );

  // Argument of P1 taken from the current window.
  always_comb begin
    p1_in = r_q[0] ^ r_q[7] ^ rotl32(r_q[13], 15);
  end

  // Word that enters the top of the window on the next shift.
  always_comb begin
    n_word = p1_out ^ rotl32(r_q[3], 7) ^ r_q[10];
  end

  // Handshake control, window load/shift and round counting.
  always_comb begin
    state_d            = state_q;
    j_d                = j_q;
    r_d                = r_q;
    done_d             = 1'b0;
    output_block_ready = 1'b0;
    output_w_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        output_block_ready = 1'b1;
        if (input_block_valid) begin
          for (int k = 0; k < SM3_BLOCK_WORDS; k++) begin
            r_d[k] = input_block[32*k +: 32];
          end
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        output_w_valid = 1'b1;
        if (input_w_ready) begin
          for (int k = 0; k < SM3_BLOCK_WORDS - 1; k++) begin
            r_d[k] = r_q[k+1];
          end
          r_d[SM3_BLOCK_WORDS-1] = n_word;
          // The 6-bit counter wraps 63 -> 0 on the final round.
          j_d = j_q + 6'd1;
          if (j_q == 6'(SM3_ROUNDS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge input_clk) begin
    if (input_rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < SM3_BLOCK_WORDS; k++) begin
        r_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      done_q  <= done_d;
      r_q     <= r_d;
    end
  end

  assign output_w    = r_q[0];
  assign output_wp   = r_q[0] ^ r_q[4];
  assign output_j    = j_q;
  assign output_done = done_q;

endmodule

// File: tb/tb_sm3_msg_expander.sv
// tb/tb_sm3_msg_expander.sv - self-checking bench for sm3_msg_expander
module tb_sm3_msg_expander;

  logic         input_clk = 1'b0;
  logic         input_rst;
  logic         input_block_valid;
  logic [0:511] input_block;
  logic         output_block_ready;
  logic         output_w_valid;
  logic         input_w_ready;
  logic [0:31]  output_w;
  logic [0:31]  output_wp;
  logic [5:0]   output_j;
  logic         output_done;

  sm3_msg_expander dut (
    .input_clk          (input_clk),
    .input_rst          (input_rst),
    .input_block_valid  (input_block_valid),
    .input_block        (input_block),
    .output_block_ready (output_block_ready),
    .output_w_valid     (output_w_valid),
    .input_w_ready      (input_w_ready),
    .output_w           (output_w),
    .output_wp          (output_wp),
    .output_j           (output_j),
    .output_done        (output_done)
  );

  always #5 input_clk = ~input_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:511] abc_blk;
  logic [0:511] ones_blk;
  logic [0:511] other_blk;

  // Expected expansion of the block currently being streamed.
  logic [31:0] exp_w [0:67];
  logic [31:0] cap_w  [0:63];
  logic [31:0] cap_wp [0:63];

  bit mon_en   = 1'b0;
  bit exp_busy = 1'b0;
  bit exp_done = 1'b0;
  int exp_j    = 0;
  int done_cnt = 0;
  int accept_cnt = 0;
  int cyc = 0;
  int accept_cyc_prev = 0;
  int accept_cyc_last = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1m(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  // Standard SM3 recurrence over the full 68-word array.
  task automatic expand(input logic [0:511] b);
    for (int i = 0; i < 16; i++) exp_w[i] = b[32*i +: 32];
    for (int i = 16; i < 68; i++)
      exp_w[i] = p1m(exp_w[i-16] ^ exp_w[i-9] ^ rl(exp_w[i-3], 15)) ^ rl(exp_w[i-13], 7) ^ exp_w[i-6];
  endtask

  always @(posedge input_clk) cyc++;

  // Compare DUT against the model each cycle, then advance the model for the coming edge.
  always @(negedge input_clk) begin
    if (mon_en) begin
      chk("block_ready", {63'd0, output_block_ready}, {63'd0, !exp_busy});
      chk("w_valid", {63'd0, output_w_valid}, {63'd0, exp_busy});
      chk("done", {63'd0, output_done}, {63'd0, exp_done});
      chk("j", {58'd0, output_j}, 64'(exp_j));
      if (output_done) done_cnt++;
      if (exp_busy) begin
        chk("w", {32'd0, output_w}, {32'd0, exp_w[exp_j]});
        chk("wp", {32'd0, output_wp}, {32'd0, exp_w[exp_j] ^ exp_w[exp_j+4]});
        cap_w[exp_j]  = output_w;
        cap_wp[exp_j] = output_wp;
      end
      exp_done = 1'b0;
      if (input_rst) begin
        exp_busy = 1'b0;
        exp_j    = 0;
      end else if (!exp_busy && input_block_valid) begin
        expand(input_block);
        exp_busy = 1'b1;
        exp_j    = 0;
        accept_cnt++;
        accept_cyc_prev = accept_cyc_last;
        accept_cyc_last = cyc;
      end else if (exp_busy && input_w_ready) begin
        if (exp_j == 63) begin
          exp_busy = 1'b0;
          exp_done = 1'b1;
        end
        exp_j = (exp_j + 1) % 64;
      end
    end
  end

  task automatic abc_literals(input string tag);
    chk({tag, "_w0"},   {32'd0, cap_w[0]},   64'h61626380);
    chk({tag, "_wp0"},  {32'd0, cap_wp[0]},  64'h61626380);
    chk({tag, "_wp12"}, {32'd0, cap_wp[12]}, 64'h9092e200);
    chk({tag, "_w15"},  {32'd0, cap_w[15]},  64'h00000018);
    chk({tag, "_wp15"}, {32'd0, cap_wp[15]}, 64'h719c70f5);
    chk({tag, "_w16"},  {32'd0, cap_w[16]},  64'h9092e200);
  endtask

  task automatic run_block(input string tag, input logic [0:511] b, input bit stall, input bit toggle);
    int d0;
    int a0;
    int n;
    d0 = done_cnt;
    a0 = accept_cnt;
    input_block       = b;
    input_block_valid = 1'b1;
    input_w_ready     = 1'b1;
    n = 0;
    while (accept_cnt == a0 && n < 10) begin
      @(posedge input_clk); #1;
      n++;
    end
    if (accept_cnt == a0) timeout({tag, "_accept"});
    input_block_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 1000) begin
      input_w_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (toggle) begin
        input_block       = other_blk;
        input_block_valid = (n < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(posedge input_clk); #1;
      n++;
    end
    if (done_cnt == d0) timeout({tag, "_done"});
    input_block_valid = 1'b0;
    input_w_ready     = 1'b1;
    repeat (3) @(posedge input_clk);
    #1;
    chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_accept_count"}, 64'(accept_cnt - a0), 64'd1);
  endtask

  initial begin
    int n;
    int d0;
    int a0;
    abc_blk   = {32'h61626380, 448'd0, 32'h00000018};
    ones_blk  = {512{1'b1}};
    other_blk = {16{32'hdeadbeef}};
    input_rst         = 1'b1;
    input_block_valid = 1'b0;
    input_block       = '0;
    input_w_ready     = 1'b0;
    @(posedge input_clk); #1;
    mon_en = 1'b1;
    @(posedge input_clk); #1;
    input_rst = 1'b0;
    chk("reset_w", {32'd0, output_w}, 64'd0);
    chk("reset_wp", {32'd0, output_wp}, 64'd0);

    // Pin the model against hand-computed values.
    expand(abc_blk);
    chk("model_abc_w16", {32'd0, exp_w[16]}, 64'h9092e200);
    chk("model_abc_wp15", {32'd0, exp_w[15] ^ exp_w[19]}, 64'h719c70f5);
    expand(ones_blk);
    chk("model_ones_w63", {32'd0, exp_w[63]}, 64'hffffffff);
    chk("model_ones_wp40", {32'd0, exp_w[40] ^ exp_w[44]}, 64'd0);

    run_block("abc", abc_blk, 1'b0, 1'b0);
    abc_literals("abc");

    run_block("stall", abc_blk, 1'b1, 1'b0);
    abc_literals("stall");

    run_block("toggle", abc_blk, 1'b0, 1'b1);

    // Back-to-back blocks with valid held high.
    d0 = done_cnt;
    a0 = accept_cnt;
    input_block       = abc_blk;
    input_block_valid = 1'b1;
    input_w_ready     = 1'b1;
    n = 0;
    while (accept_cnt < a0 + 2 && n < 300) begin
      @(posedge input_clk); #1;
      n++;
    end
    if (accept_cnt < a0 + 2) timeout("b2b_accept");
    input_block_valid = 1'b0;
    n = 0;
    while (done_cnt < d0 + 2 && n < 300) begin
      @(posedge input_clk); #1;
      n++;
    end
    if (done_cnt < d0 + 2) timeout("b2b_done");
    chk("b2b_interval", 64'(accept_cyc_last - accept_cyc_prev), 64'd65);
    repeat (2) @(posedge input_clk);
    #1;

    // Reset in the middle of a block.
    d0 = done_cnt;
    a0 = accept_cnt;
    input_block       = abc_blk;
    input_block_valid = 1'b1;
    n = 0;
    while (accept_cnt == a0 && n < 10) begin
      @(posedge input_clk); #1;
      n++;
    end
    if (accept_cnt == a0) timeout("rst_accept");
    input_block_valid = 1'b0;
    n = 0;
    while (output_j != 6'd30 && n < 100) begin
      @(posedge input_clk); #1;
      n++;
    end
    if (output_j != 6'd30) timeout("rst_j30");
    input_rst = 1'b1;
    @(posedge input_clk); #1;
    input_rst = 1'b0;
    chk("rst_w_valid", {63'd0, output_w_valid}, 64'd0);
    chk("rst_ready", {63'd0, output_block_ready}, 64'd1);
    repeat (80) @(posedge input_clk);
    #1;
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
    run_block("post_rst", abc_blk, 1'b0, 1'b0);
    abc_literals("post_rst");

    run_block("ones", ones_blk, 1'b0, 1'b0);
    chk("ones_j_wrapped", {58'd0, output_j}, 64'd0);

    repeat (3) @(posedge input_clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm3_msg_expander.md
SM3_MSG_EXPANDER -- requirements
Module: sm3_msg_expander

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 input_clk  in  1  rising-edge clock for all state.
REQ-003 input_rst  in  1  synchronous active-high reset.
REQ-004 input_block_valid  in  1  the 512-bit padded message block is presented.
REQ-005 input_block  in  512  block, bit 0 = MSB, word W0 = bits [0:31] through W15 = bits [480:511].
REQ-006 output_block_ready  out  1  high only in IDLE; a block is accepted when valid&ready.
REQ-007 output_w_valid  out  1  the round word pair for round output_j is presented.
REQ-008 input_w_ready  in  1  the compression engine accepts the current pair.
REQ-009 output_w  out  32  W_j, bit 0 = MSB.
REQ-010 output_wp  out  32  W'_j = W_j ^ W_{j+4}.
REQ-011 output_j  out  6  round index 0..63, the same encoding the round boolean functions use.
REQ-012 output_done  out  1  one-cycle pulse after round 63 is accepted.

Function
REQ-013 The block SHALL hold a 16-word window R[0..15] where R[k] = W_{j+k} at round j.
REQ-014 output_w SHALL be R[0], and output_wp SHALL be R[0]^R[4], both combinational from registers with no arithmetic on the output path beyond this XOR.
REQ-015 The new word SHALL be N = P1(R[0]^R[7]^(R[13]<<<15)) ^ (R[3]<<<7) ^ R[10], where P1(x) = x^(x<<<15)^(x<<<23) and <<< is a 32-bit rotate-left.
REQ-016 On each accepted pair (w_valid&w_ready), R SHALL shift (R[k]<=R[k+1], R[15]<=N) and j SHALL increment.
REQ-017 The FSM SHALL have two states, IDLE and RUN.
REQ-018 IDLE: block_ready=1, w_valid=0; on valid&ready, load R[k]=Wk, set j=0, and go to RUN.
REQ-019 RUN: block_ready=0, w_valid=1.
REQ-020 In RUN, when w_ready=0, R, j, output_w, output_wp and output_j SHALL hold stable.
REQ-021 In RUN, on a handshake with j=63, the block SHALL return to IDLE, assert output_done for exactly the next cycle, and leave j wrapped to 0.
REQ-022 The first W pair SHALL appear the cycle after block acceptance, and the throughput SHALL be one pair per cycle with w_ready held high.
REQ-023 The minimum period between blocks SHALL be 65 cycles; block_ready reasserts in the same cycle done pulses.
REQ-024 input_block_valid SHALL be ignored in RUN, with no queuing.

Reset
REQ-025 On input_rst=1 at a clock edge, the state SHALL go to IDLE, j=0, R=all zero, output_done=0, w_valid=0, and block_ready=1 in the next cycle.
REQ-026 Reset mid-RUN SHALL abort the block with no done pulse, and w_valid SHALL drop in the cycle following the reset edge.
REQ-027 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-028 The shared package sm3_pkg SHALL hold: SM3_ROUNDS=64, SM3_BLOCK_WORDS=16, the sm3_word_t 32-bit [0:31] typedef, the expander state enum {IDLE, RUN}, and a rotl32 function.
REQ-029 The sub-module sm3_p1 SHALL be a combinational P1 permutation, instantiated once for N.
REQ-030 All registers SHALL be in a single always_ff block, and next-state/N logic SHALL be in always_comb.

Verification
REQ-031 "abc" block (61626380, 0 x14, 00000018), w_ready=1 -> j=0: w=61626380, wp=61626380; j=12: wp=9092e200; j=15: w=00000018, wp=719c70f5; j=16: w=9092e200.
REQ-032 The same block with random w_ready backpressure -> the sequence of 64 (w, wp, j) triples SHALL be identical to the stall-free run; outputs SHALL be stable while stalled; done SHALL pulse once.
REQ-033 Two back-to-back blocks with valid held high -> the second accept SHALL occur in the done cycle, and the interval between accepts SHALL be 65 cycles.
REQ-034 input_rst asserted at j=30 -> next cycle IDLE with w_valid=0 and no done; a following "abc" block SHALL reproduce REQ-031 values.
REQ-035 input_block_valid toggling during RUN with a different block -> there SHALL be no effect on the output stream, and block_ready SHALL stay 0.
REQ-036 All-ones block (FFFFFFFF x16) -> a W/W' stream SHALL match a software model for all 64 rounds; j SHALL count 0..63 and then wrap.
